// File: rtl/branch_predict_unit.sv
// Fetch-time next-PC predictor backed by a direct-mapped BTB with saturating
// direction counters; checks the held prediction against the D-stage outcome.
module branch_predict_unit #(
    parameter int PC_W   = 32,
    parameter int IDX_W  = 6,
    parameter int CNT_W  = 2,
    parameter int STAT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PC_W-1:0]   f_pc,
    output logic              pred_taken,
    output logic [PC_W-1:0]   pred_target,
    input  logic              stall_d,
    input  logic              flush_d,
    input  logic              d_valid,
    input  logic [PC_W-1:0]   d_pc,
    input  logic              d_is_br,
    input  logic              d_is_jmp,
    input  logic              d_taken,
    input  logic [PC_W-1:0]   d_target,
    output logic              redirect,
    output logic [PC_W-1:0]   redirect_pc,
    output logic [STAT_W-1:0] br_count,
    output logic [STAT_W-1:0] mis_count
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = PC_W - IDX_W - 2;

    localparam logic [PC_W-1:0]   PC_STEP   = {{(PC_W-3){1'b0}}, 3'b100};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_WT    = {1'b1, {(CNT_W-1){1'b0}}};
    localparam logic [CNT_W-1:0]  CNT_WNT   = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [STAT_W-1:0] STAT_ONE  = {{(STAT_W-1){1'b0}}, 1'b1};
    localparam logic [STAT_W-1:0] STAT_MAX  = {STAT_W{1'b1}};

    function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] c, input logic up);
        logic [CNT_W-1:0] r;
        r = c;
        if (up) begin
            if (c != CNT_MAX) r = c + CNT_ONE;
            else              r = c;
        end else begin
            if (c != CNT_ZERO) r = c - CNT_ONE;
            else               r = c;
        end
        return r;
    endfunction

    function automatic logic [STAT_W-1:0] stat_inc(input logic [STAT_W-1:0] s);
        logic [STAT_W-1:0] r;
        if (s != STAT_MAX) r = s + STAT_ONE;
        else               r = s;
        return r;
    endfunction

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [ENTRIES-1:0] jmp_q, jmp_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [PC_W-1:0]    target_q [ENTRIES];
    logic [PC_W-1:0]    target_d [ENTRIES];
    logic [CNT_W-1:0]   cnt_q    [ENTRIES];
    logic [CNT_W-1:0]   cnt_d    [ENTRIES];

    logic              dp_taken_q, dp_taken_d;
    logic [PC_W-1:0]   dp_target_q, dp_target_d;
    logic [STAT_W-1:0] br_count_q, br_count_d;
    logic [STAT_W-1:0] mis_count_q, mis_count_d;

    logic [IDX_W-1:0] f_idx_s, d_idx_s;
    logic [TAG_W-1:0] f_tag_s, d_tag_s;
    logic             f_hit_s, d_hit_s;
    logic             pred_taken_s;
    logic [PC_W-1:0]  pred_target_s;
    logic             resolve_s, act_taken_s, mispredict_s;
    logic [PC_W-1:0]  act_pc_s;

    // F-stage lookup and prediction
    always_comb begin
        f_idx_s      = f_pc[IDX_W+1:2];
        f_tag_s      = f_pc[PC_W-1:IDX_W+2];
        f_hit_s      = valid_q[f_idx_s] && (tag_q[f_idx_s] == f_tag_s);
        pred_taken_s = f_hit_s && (jmp_q[f_idx_s] || cnt_q[f_idx_s][CNT_W-1]);
        if (pred_taken_s) pred_target_s = target_q[f_idx_s];
        else              pred_target_s = f_pc + PC_STEP;
    end

    // D-stage resolution against the held prediction; idle while reset is held
    always_comb begin
        resolve_s   = reset && d_valid && !stall_d && (d_is_br || d_is_jmp);
        act_taken_s = d_is_jmp || d_taken;
        if (act_taken_s) act_pc_s = d_target;
        else             act_pc_s = d_pc + PC_STEP;
        mispredict_s = resolve_s && ((act_taken_s != dp_taken_q) ||
                                     (act_taken_s && (d_target != dp_target_q)));
        d_idx_s = d_pc[IDX_W+1:2];
        d_tag_s = d_pc[PC_W-1:IDX_W+2];
        d_hit_s = valid_q[d_idx_s] && (tag_q[d_idx_s] == d_tag_s);
    end

    // BTB next state: train on hit, allocate on taken miss
    always_comb begin
        valid_d  = valid_q;
        jmp_d    = jmp_q;
        tag_d    = tag_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        if (resolve_s) begin
            if (d_hit_s) begin
                cnt_d[d_idx_s] = cnt_step(cnt_q[d_idx_s], act_taken_s);
                jmp_d[d_idx_s] = d_is_jmp;
                if (act_taken_s) target_d[d_idx_s] = d_target;
                else             target_d[d_idx_s] = target_q[d_idx_s];
            end else if (act_taken_s) begin
                valid_d[d_idx_s]  = 1'b1;
                tag_d[d_idx_s]    = d_tag_s;
                target_d[d_idx_s] = d_target;
                jmp_d[d_idx_s]    = d_is_jmp;
                if (d_is_jmp) cnt_d[d_idx_s] = CNT_MAX;
                else          cnt_d[d_idx_s] = CNT_WT;
            end else begin
                valid_d = valid_q;
            end
        end else begin
            valid_d = valid_q;
        end
    end

    // Prediction capture alongside the F/D register, plus statistics
    always_comb begin
        dp_taken_d  = dp_taken_q;
        dp_target_d = dp_target_q;
        if (flush_d) begin
            dp_taken_d  = 1'b0;
            dp_target_d = {PC_W{1'b0}};
        end else if (!stall_d) begin
            dp_taken_d  = pred_taken_s;
            dp_target_d = pred_target_s;
        end else begin
            dp_taken_d  = dp_taken_q;
            dp_target_d = dp_target_q;
        end
        if (resolve_s) br_count_d = stat_inc(br_count_q);
        else           br_count_d = br_count_q;
        if (mispredict_s) mis_count_d = stat_inc(mis_count_q);
        else              mis_count_d = mis_count_q;
    end

    // State registers; reset forgets every learned entry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q     <= {ENTRIES{1'b0}};
            jmp_q       <= {ENTRIES{1'b0}};
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= {TAG_W{1'b0}};
                target_q[i] <= {PC_W{1'b0}};
                cnt_q[i]    <= CNT_WNT;
            end
            dp_taken_q  <= 1'b0;
            dp_target_q <= {PC_W{1'b0}};
            br_count_q  <= {STAT_W{1'b0}};
            mis_count_q <= {STAT_W{1'b0}};
        end else begin
            valid_q     <= valid_d;
            jmp_q       <= jmp_d;
            tag_q       <= tag_d;
            target_q    <= target_d;
            cnt_q       <= cnt_d;
            dp_taken_q  <= dp_taken_d;
            dp_target_q <= dp_target_d;
            br_count_q  <= br_count_d;
            mis_count_q <= mis_count_d;
        end
    end

    // Output drive; redirect data is zero unless an instruction resolves
    always_comb begin
        pred_taken  = pred_taken_s;
        pred_target = pred_target_s;
        br_count    = br_count_q;
        mis_count   = mis_count_q;
        if (resolve_s) begin
            redirect    = mispredict_s;
            redirect_pc = act_pc_s;
        end else begin
            redirect    = 1'b0;
            redirect_pc = {PC_W{1'b0}};
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed + randomized bench for branch_predict_unit against a table-based
// reference predictor; STAT_W is shrunk so counter saturation is reachable.
module tb_branch_predict_unit;

    localparam int PC_W   = 32;
    localparam int IDX_W  = 6;
    localparam int CNT_W  = 2;
    localparam int STAT_W = 8;
    localparam int NENT   = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic [PC_W-1:0]   f_pc;
    logic              pred_taken;
    logic [PC_W-1:0]   pred_target;
    logic              stall_d, flush_d, d_valid, d_is_br, d_is_jmp, d_taken;
    logic [PC_W-1:0]   d_pc, d_target;
    logic              redirect;
    logic [PC_W-1:0]   redirect_pc;
    logic [STAT_W-1:0] br_count, mis_count;

    always #5 clk = ~clk;

    branch_predict_unit #(.PC_W(PC_W), .IDX_W(IDX_W), .CNT_W(CNT_W), .STAT_W(STAT_W)) dut (
        .clk(clk), .reset(reset), .f_pc(f_pc), .pred_taken(pred_taken),
        .pred_target(pred_target), .stall_d(stall_d), .flush_d(flush_d),
        .d_valid(d_valid), .d_pc(d_pc), .d_is_br(d_is_br), .d_is_jmp(d_is_jmp),
        .d_taken(d_taken), .d_target(d_target), .redirect(redirect),
        .redirect_pc(redirect_pc), .br_count(br_count), .mis_count(mis_count)
    );

    int compared = 0;
    int mismatched = 0;

    // reference model: one row per BTB slot, plain integers
    bit          m_valid [NENT];
    int unsigned m_tag   [NENT];
    logic [31:0] m_target[NENT];
    int          m_cnt   [NENT];
    bit          m_jmp   [NENT];
    bit          m_dp_taken;
    logic [31:0] m_dp_target;
    int          m_br, m_mis;

    bit          e_pred_taken, e_resolve, e_act, e_mis;
    logic [31:0] e_pred_target, e_redirect_pc;

    logic [31:0] pool [8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NENT; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = 0; m_target[i] = 32'd0;
            m_cnt[i] = 1; m_jmp[i] = 1'b0;
        end
        m_dp_taken = 1'b0; m_dp_target = 32'd0; m_br = 0; m_mis = 0;
    endtask

    task automatic model_eval();
        int unsigned fi;
        bit hit;
        fi  = (f_pc >> 2) % NENT;
        hit = m_valid[fi] && (m_tag[fi] == (f_pc >> 8));
        e_pred_taken  = reset && hit && (m_jmp[fi] || m_cnt[fi] >= 2);
        e_pred_target = e_pred_taken ? m_target[fi] : f_pc + 32'd4;
        e_resolve = reset && d_valid && !stall_d && (d_is_br || d_is_jmp);
        e_act     = d_is_jmp || d_taken;
        e_mis     = e_resolve && ((e_act != m_dp_taken) || (e_act && d_target != m_dp_target));
        e_redirect_pc = e_resolve ? (e_act ? d_target : d_pc + 32'd4) : 32'd0;
    endtask

    task automatic model_clock();
        int unsigned di;
        bit hit;
        if (reset) begin
            di  = (d_pc >> 2) % NENT;
            hit = m_valid[di] && (m_tag[di] == (d_pc >> 8));
            if (e_resolve) begin
                if (m_br < 255) m_br++;
                if (e_mis && m_mis < 255) m_mis++;
                if (hit) begin
                    if (e_act) begin
                        if (m_cnt[di] < 3) m_cnt[di]++;
                        m_target[di] = d_target;
                    end else if (m_cnt[di] > 0) m_cnt[di]--;
                    m_jmp[di] = d_is_jmp;
                end else if (e_act) begin
                    m_valid[di] = 1'b1; m_tag[di] = d_pc >> 8; m_target[di] = d_target;
                    m_jmp[di] = d_is_jmp; m_cnt[di] = d_is_jmp ? 3 : 2;
                end
            end
            if (flush_d) begin
                m_dp_taken = 1'b0; m_dp_target = 32'd0;
            end else if (!stall_d) begin
                m_dp_taken = e_pred_taken; m_dp_target = e_pred_target;
            end
        end
    endtask

    // called just after a falling edge with inputs already driven
    task automatic prep(input string lbl);
        if (!reset) model_reset();
        #1;
        model_eval();
        chk({lbl, "/pred_taken"},  {31'd0, pred_taken}, {31'd0, e_pred_taken});
        chk({lbl, "/pred_target"}, pred_target, e_pred_target);
        chk({lbl, "/redirect"},    {31'd0, redirect}, {31'd0, e_mis});
        chk({lbl, "/redirect_pc"}, redirect_pc, e_redirect_pc);
        chk({lbl, "/br_count"},    {24'd0, br_count}, m_br);
        chk({lbl, "/mis_count"},   {24'd0, mis_count}, m_mis);
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic idle_d();
        d_valid = 1'b0; d_pc = 32'd0; d_is_br = 1'b0; d_is_jmp = 1'b0;
        d_taken = 1'b0; d_target = 32'd0; stall_d = 1'b0; flush_d = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] pc, input string lbl);
        idle_d();
        f_pc = pc;
        prep(lbl);
    endtask

    task automatic resolve(input logic [31:0] pc, input bit jmp, input bit tk,
                           input logic [31:0] tgt, input logic [31:0] fpc, input string lbl);
        idle_d();
        d_valid = 1'b1; d_pc = pc; d_is_br = !jmp; d_is_jmp = jmp;
        d_taken = tk; d_target = tgt; f_pc = fpc;
        prep(lbl);
    endtask

    initial begin
        pool[0] = 32'h3000; pool[1] = 32'h3004; pool[2] = 32'h3010; pool[3] = 32'h3100;
        pool[4] = 32'h3104; pool[5] = 32'h3200; pool[6] = 32'h7ffc; pool[7] = 32'hfffffffc;
        idle_d();
        f_pc = 32'h0;
        reset = 1'b1;
        #1 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        f_pc = 32'h3000;
        prep("reset");
        chk("reset/pred_taken_lit", {31'd0, pred_taken}, 32'd0);
        tick();
        reset = 1'b1;

        // cold start and counter training
        fetch(32'h3000, "cold_fetch");
        chk("cold_pred", {31'd0, pred_taken}, 32'd0);
        tick();
        resolve(32'h3000, 1'b0, 1'b1, 32'h3040, 32'h3004, "cold_res");
        chk("cold_redir", {31'd0, redirect}, 32'd1);
        chk("cold_redir_pc", redirect_pc, 32'h3040);
        tick();
        fetch(32'h3000, "refetch");
        chk("refetch_pred", {31'd0, pred_taken}, 32'd1);
        chk("refetch_tgt", pred_target, 32'h3040);
        tick();
        resolve(32'h3000, 1'b0, 1'b0, 32'h3040, 32'h3004, "nt1");
        chk("nt1_redir_pc", redirect_pc, 32'h3004);
        tick();
        for (int k = 0; k < 2; k++) begin
            fetch(32'h3000, "nt_fetch");
            chk("nt_pred", {31'd0, pred_taken}, 32'd0);
            tick();
            resolve(32'h3000, 1'b0, 1'b0, 32'h3040, 32'h3004, "nt_res");
            chk("nt_redir", {31'd0, redirect}, 32'd0);
            tick();
        end
        resolve(32'h3000, 1'b0, 1'b1, 32'h3040, 32'h3004, "sat_up");
        tick();
        fetch(32'h3000, "sat_fetch");
        chk("sat_pred", {31'd0, pred_taken}, 32'd0);
        tick();

        // indirect jump retargeting
        resolve(32'h3010, 1'b1, 1'b0, 32'h3100, 32'h3014, "jr1");
        chk("jr1_redir_pc", redirect_pc, 32'h3100);
        tick();
        fetch(32'h3010, "jr_fetch1");
        chk("jr_tgt1", pred_target, 32'h3100);
        tick();
        resolve(32'h3010, 1'b1, 1'b0, 32'h3200, 32'h3014, "jr2");
        chk("jr2_redir", {31'd0, redirect}, 32'd1);
        chk("jr2_redir_pc", redirect_pc, 32'h3200);
        tick();
        fetch(32'h3010, "jr_fetch2");
        chk("jr_tgt2", pred_target, 32'h3200);
        tick();

        // stall holds the captured prediction and suppresses resolution
        for (int k = 0; k < 3; k++) begin
            resolve(32'h3010, 1'b1, 1'b0, 32'h3200, 32'h3000, "stall");
            stall_d = 1'b1;
            prep("stall_on");
            chk("stall_redir", {31'd0, redirect}, 32'd0);
            tick();
        end
        resolve(32'h3010, 1'b1, 1'b0, 32'h3200, 32'h3000, "stall_rel");
        chk("stall_rel_redir", {31'd0, redirect}, 32'd0);
        tick();

        // flush clears the captured prediction
        fetch(32'h3010, "flush");
        flush_d = 1'b1;
        prep("flush_on");
        tick();
        resolve(32'h3010, 1'b1, 1'b0, 32'h3200, 32'h3014, "after_flush");
        chk("flush_redir", {31'd0, redirect}, 32'd1);
        tick();

        // invalid D slot never resolves
        fetch(32'h3010, "inv_fetch");
        tick();
        resolve(32'h3010, 1'b1, 1'b0, 32'h9990, 32'h3014, "inv");
        d_valid = 1'b0;
        prep("inv_d");
        chk("inv_redir", {31'd0, redirect}, 32'd0);
        tick();

        // two PCs aliasing onto one slot
        for (int k = 0; k < 3; k++) begin
            fetch(32'h3000, "alias_fa");
            tick();
            resolve(32'h3000, 1'b0, 1'b1, 32'h3040, 32'h3004, "alias_a");
            chk("alias_a_redir", {31'd0, redirect}, 32'd1);
            tick();
            fetch(32'h3100, "alias_fb");
            tick();
            resolve(32'h3100, 1'b0, 1'b1, 32'h3180, 32'h3104, "alias_b");
            chk("alias_b_redir", {31'd0, redirect}, 32'd1);
            tick();
        end

        // randomized traffic; long enough to saturate the 8-bit branch counter
        for (int k = 0; k < 700; k++) begin
            f_pc     = pool[$urandom_range(0, 7)];
            d_pc     = pool[$urandom_range(0, 7)];
            d_target = pool[$urandom_range(0, 7)];
            d_valid  = ($urandom_range(0, 9) < 8);
            d_is_jmp = ($urandom_range(0, 3) == 0);
            d_is_br  = ($urandom_range(0, 1) == 1);
            d_taken  = $urandom_range(0, 1);
            stall_d  = ($urandom_range(0, 4) == 0);
            flush_d  = ($urandom_range(0, 9) == 0);
            prep("rand");
            tick();
        end

        // mid-run reset discards training
        resolve(32'h3010, 1'b1, 1'b0, 32'h3200, 32'h3014, "pre_rst_train");
        tick();
        fetch(32'h3010, "pre_rst_fetch");
        chk("pre_rst_pred", {31'd0, pred_taken}, 32'd1);
        tick();
        resolve(32'h3010, 1'b1, 1'b0, 32'h3300, 32'h3010, "in_rst");
        reset = 1'b0;
        prep("in_rst");
        chk("rst_pred", {31'd0, pred_taken}, 32'd0);
        chk("rst_tgt", pred_target, 32'h3014);
        chk("rst_redir", {31'd0, redirect}, 32'd0);
        chk("rst_br", {24'd0, br_count}, 32'd0);
        chk("rst_mis", {24'd0, mis_count}, 32'd0);
        tick();
        reset = 1'b1;
        fetch(32'h3010, "post_rst_fetch");
        chk("post_rst_pred", {31'd0, pred_taken}, 32'd0);
        tick();
        resolve(32'h3010, 1'b1, 1'b0, 32'h3200, 32'h3014, "post_rst_res");
        chk("post_rst_redir", {31'd0, redirect}, 32'd1);
        tick();

        for (int k = 0; k < 100; k++) begin
            f_pc     = pool[$urandom_range(0, 7)];
            d_pc     = pool[$urandom_range(0, 7)];
            d_target = pool[$urandom_range(0, 7)];
            d_valid  = $urandom_range(0, 1);
            d_is_jmp = ($urandom_range(0, 3) == 0);
            d_is_br  = $urandom_range(0, 1);
            d_taken  = $urandom_range(0, 1);
            stall_d  = ($urandom_range(0, 4) == 0);
            flush_d  = ($urandom_range(0, 9) == 0);
            prep("rand2");
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
- Next-generation PC-select block: moves next-PC choice from decode-only resolution to fetch-time prediction with decode-time correction.
- Holds a direct-mapped branch target buffer (BTB) with per-entry saturating direction counters.
- Predicts next PC for the instruction in F, remembers that prediction while the instruction sits in D, compares it against the branch/jump outcome resolved in D, and issues a redirect on mispredict.
- Sits between the PC register, the F/D pipeline register and the D-stage comparator; keeps branch/mispredict statistics counters.

Parameters:
- PC_W, 32, PC width in bits; PC is word aligned, bits [1:0] ignored.
- IDX_W, 6, BTB index width; 2^IDX_W entries, indexed by pc[IDX_W+1:2].
- CNT_W, 2, direction counter width (CNT_W >= 2).
- STAT_W, 32, width of the statistics counters.

Ports:
- clk  input  1  pipeline clock
- reset  input  1  asynchronous, active-low reset
- f_pc  input  PC_W  PC of the instruction being fetched
- pred_taken  output  1  F-stage prediction: redirect fetch to pred_target
- pred_target  output  PC_W  predicted next PC (f_pc+4 when not predicted taken)
- stall_d  input  1  D stage frozen; F/D register holds
- flush_d  input  1  F/D register loads a bubble this cycle
- d_valid  input  1  D holds a real instruction
- d_pc  input  PC_W  PC of the D-stage instruction
- d_is_br  input  1  D instruction is a conditional branch
- d_is_jmp  input  1  D instruction is an unconditional jump (j, jal, jr, jalr)
- d_taken  input  1  resolved direction (comparator result; ignored if d_is_jmp)
- d_target  input  PC_W  resolved taken target
- redirect  output  1  mispredict; PC must load redirect_pc
- redirect_pc  output  PC_W  corrected next PC
- br_count  output  STAT_W  resolved control-transfer instructions
- mis_count  output  STAT_W  mispredicts

Behaviour:
- BTB entry contents: valid, tag = pc[PC_W-1:IDX_W+2], target[PC_W], cnt[CNT_W], jmp flag.
- Lookup is combinational from f_pc.
- hit = valid && tag match.
- pred_taken = hit && (jmp || cnt MSB).
- pred_target = pred_taken ? target : f_pc+4 (mod 2^PC_W, wraps).
- Prediction capture: when !stall_d, the registers dp_taken and dp_target load pred_taken and pred_target (flush_d loads 0 and 0); when stall_d, they hold. flush_d has priority over stall_d.
- A D-stage instruction resolves when d_valid && !stall_d && (d_is_br || d_is_jmp).
  - act_taken = d_is_jmp | d_taken.
  - act_pc = act_taken ? d_target : d_pc+4.
- Mispredict = resolve && (act_taken != dp_taken || (act_taken && d_target != dp_target)).
- redirect = Mispredict, combinational; redirect_pc = act_pc. Both are 0 when not resolving.
- The core has no delay slot; upstream flushes the wrong-path F instruction on redirect.
- BTB update on resolve, written at the clock edge, index and tag taken from d_pc:
  - Hit: cnt saturating +1 if act_taken, -1 if not, clamped to [0, 2^CNT_W-1]; target <= d_target if act_taken; jmp <= d_is_jmp.
  - Miss and act_taken: allocate (overwrite). valid=1, tag, target=d_target, jmp=d_is_jmp, cnt = 2^(CNT_W-1) (weakly taken), or all ones if jump.
  - Miss and not taken: no write.
- Same-cycle read/write to the same index: lookup sees the old contents (no bypass).
- Statistics: br_count +1 per resolve; mis_count +1 per mispredict. Both saturate at all ones and never wrap.
- Reset (async, reset low): all valid=0, all cnt = 2^(CNT_W-1)-1 (weakly not taken), dp_taken=0, dp_target=0, br_count=0, mis_count=0.
  - Outputs during reset: pred_taken=0, pred_target=f_pc+4, redirect=0.
  - Reset mid-operation discards all learned state; first cycle after release behaves as cold start.
- Instructions with d_valid low, or non-branch, never update the BTB or counters, even if dp_taken is set (stale alias impossible after flush).

Test Plan:
- Cold start, beq at 0x3000 taken to 0x3040 -> pred_taken=0, redirect=1, redirect_pc=0x3040, entry allocated cnt=2'b10; refetch 0x3000 -> pred_taken=1, pred_target=0x3040.
- Same beq resolves not taken twice -> first: redirect_pc=0x3004, cnt=01; second: pred_taken=0, no redirect, cnt=00; further not-taken stays 00 (saturation).
- jr at 0x3010 to 0x3100, then to 0x3200 -> second execution predicted 0x3100, redirect=1, redirect_pc=0x3200, target updated to 0x3200.
- stall_d=1 for 3 cycles with branch in D -> redirect=0 and no count change while stalled; single resolve/update on the release cycle; dp_* unchanged across the stall.
- Aliasing: 0x3000 and 0x3000+4*2^IDX_W both taken, alternating -> each misses the tag, redirects and overwrites; mis_count increments each time.
- Assert reset low mid-run with BTB trained -> immediate pred_taken=0, counters 0; after release, the first taken branch mispredicts again.
